// File: rtl/uart_rx_if.sv
// uart_rx_if -- serial line and received-byte bundle for uart_rx.
//   rx        : asynchronous serial line, idle high (driven by the sender)
//   po_data   : last correctly received byte
//   po_flag   : one-cycle pulse, po_data valid in the same cycle
//   frame_err : one-cycle pulse when a stop bit samples 0
// Modports:
//   master : the receiver (consumes rx, produces the byte outputs)
//   slave  : the sender/consumer side (drives rx, observes the byte outputs)
interface uart_rx_if;
    logic       rx;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;

    modport master (
        input  rx,
        output po_data,
        output po_flag,
        output frame_err
    );

    modport slave (
        output rx,
        input  po_data,
        input  po_flag,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 RS232 receiver, mid-bit sampling.
//   sys_clk   : system clock (CLK_FREQ Hz)
//   sys_rst_n : synchronous active-low reset
//   rx_bus    : uart_rx_if.master (rx in; po_data, po_flag, frame_err out)
// Parameters: UART_BPS (baud rate), CLK_FREQ (sys_clk frequency in Hz).
module uart_rx #(
    parameter int unsigned UART_BPS = 'd9600,
    parameter int unsigned CLK_FREQ = 'd50_000_000
) (
    input  logic      sys_clk,
    input  logic      sys_rst_n,
    uart_rx_if.master rx_bus
);

    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned HALF         = BAUD_CNT_MAX / 2;
    localparam int unsigned CNT_W        = $clog2(BAUD_CNT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             rx_d1;
    logic             rx_d2;
    logic             rx_d3;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic [7:0]       po_data;
    logic             po_flag;
    logic             frame_err;

    logic             start_det;
    logic             sample;
    logic             load_out;
    logic             err_out;

    assign start_det = (rx_d2 == 1'b0) && (rx_d3 == 1'b1);
    assign sample    = (baud_cnt == CNT_W'(HALF));

    // Synchronizer flops reset high so a reset release never looks like an edge.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
            rx_d3 <= 1'b1;
        end else begin
            rx_d1 <= rx_bus.rx;
            rx_d2 <= rx_d1;
            rx_d3 <= rx_d2;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        err_out    = 1'b0;
        case (state)
            IDLE: begin
                if (start_det) begin
                    state_next = START;
                end
            end
            START: begin
                if (sample) begin
                    state_next = rx_d2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample && (bit_cnt == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop so a back-to-back start edge is caught.
                if (sample) begin
                    if (rx_d2) begin
                        load_out   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_out    = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_d2) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            po_data   <= '0;
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Zeroed on the way into IDLE/BREAK too, so IDLE always sees 0.
            if ((state == IDLE) || (state_next == IDLE) || (state_next == BREAK)) begin
                baud_cnt <= '0;
            end else if (baud_cnt == CNT_W'(BAUD_CNT_MAX - 1)) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end

            if ((state == START) && sample) begin
                bit_cnt <= '0;
            end else if ((state == DATA) && sample) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            // Right shift: first (LSB) bit ends up in shift[0] after 8 samples.
            if ((state == DATA) && sample) begin
                shift <= {rx_d2, shift[7:1]};
            end

            po_flag   <= load_out;
            frame_err <= err_out;
            if (load_out) begin
                po_data <= shift;
            end
        end
    end

    assign rx_bus.po_data   = po_data;
    assign rx_bus.po_flag   = po_flag;
    assign rx_bus.frame_err = frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scoreboard bench for uart_rx at a scaled baud (50 clocks/bit).
module tb_uart_rx;

    localparam int unsigned BAUD = 50;
    localparam int unsigned HALF = BAUD / 2;
    // Pin change at cycle n -> start detect t0 = n+2 -> pulse at t0+2+HALF+9*BAUD.
    localparam int unsigned LAT  = 4 + HALF + 9 * BAUD;

    typedef struct {
        logic [7:0]  d;
        int unsigned t;   // 0: time not checked
    } exp_t;

    logic        sys_clk;
    logic        sys_rst_n;
    int unsigned cyc;
    int unsigned n_total;
    int unsigned n_bad;
    int unsigned n_flags;
    int unsigned n_ferr;
    logic [7:0]  last_good;
    exp_t        sb[$];
    int unsigned ferr_q[$];
    int unsigned flag_cyc[$];
    exp_t        e_mon;
    int unsigned t_mon;

    uart_rx_if bus ();

    uart_rx #(
        .UART_BPS (100_000),
        .CLK_FREQ (5_000_000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_bus    (bus.master)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Call at a negedge; leaves rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned per,
                              input logic chk_t);
        exp_t e;
        e.d = d;
        e.t = chk_t ? cyc + LAT : 0;
        if (stop) sb.push_back(e);
        else      ferr_q.push_back(chk_t ? cyc + LAT : 0);
        bus.rx = 1'b0;
        repeat (per) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            repeat (per) @(negedge sys_clk);
        end
        bus.rx = stop;
        repeat (per) @(negedge sys_clk);
    endtask

    task automatic idle(input int unsigned n);
        bus.rx = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    // Output monitor: every pulse must match the head of its queue.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (bus.po_flag || bus.frame_err)
                chk("flag_err_excl", {31'd0, bus.po_flag & bus.frame_err}, 32'd0);
            if (bus.po_flag) begin
                n_flags++;
                flag_cyc.push_back(cyc);
                chk("flag_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e_mon = sb.pop_front();
                    chk("po_data", {24'd0, bus.po_data}, {24'd0, e_mon.d});
                    if (e_mon.t != 0) chk("flag_time", cyc, e_mon.t);
                    last_good = e_mon.d;
                end
            end
            if (bus.frame_err) begin
                n_ferr++;
                chk("ferr_expected", {31'd0, ferr_q.size() != 0}, 32'd1);
                if (ferr_q.size() != 0) begin
                    t_mon = ferr_q.pop_front();
                    if (t_mon != 0) chk("ferr_time", cyc, t_mon);
                end
                chk("ferr_hold_data", {24'd0, bus.po_data}, {24'd0, last_good});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned f0;
        int unsigned e0;
        int unsigned idx;
        int unsigned waited;
        logic [7:0]  c5;
        logic [7:0]  rb;

        n_total   = 0;
        n_bad     = 0;
        n_flags   = 0;
        n_ferr    = 0;
        last_good = 8'h00;
        sys_rst_n = 1'b0;
        bus.rx    = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_po_data", {24'd0, bus.po_data}, 32'd0);
        chk("rst_po_flag", {31'd0, bus.po_flag}, 32'd0);
        chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        sys_rst_n = 1'b1;
        idle(20);

        // Single nominal frame with exact latency check.
        f0 = n_flags;
        send_frame(8'h55, 1'b1, BAUD, 1'b1);
        idle(100);
        chk("single_flags", n_flags - f0, 1);

        // Back-to-back frames.
        f0  = n_flags;
        idx = flag_cyc.size();
        send_frame(8'hA3, 1'b1, BAUD, 1'b1);
        send_frame(8'h00, 1'b1, BAUD, 1'b1);
        send_frame(8'hFF, 1'b1, BAUD, 1'b1);
        idle(100);
        chk("b2b_flags", n_flags - f0, 3);
        if (flag_cyc.size() >= idx + 3) begin
            chk("b2b_gap1", flag_cyc[idx+1] - flag_cyc[idx], 10 * BAUD);
            chk("b2b_gap2", flag_cyc[idx+2] - flag_cyc[idx+1], 10 * BAUD);
        end

        // Short low glitch, then a good frame.
        f0 = n_flags;
        e0 = n_ferr;
        bus.rx = 1'b0;
        repeat (10) @(negedge sys_clk);
        idle(100);
        chk("glitch_flags", n_flags - f0, 0);
        chk("glitch_ferr", n_ferr - e0, 0);
        send_frame(8'h3C, 1'b1, BAUD, 1'b1);
        idle(100);

        // Stop bit 0, line held low 3 more bit times, then recovery.
        f0 = n_flags;
        e0 = n_ferr;
        send_frame(8'h81, 1'b0, BAUD, 1'b1);
        repeat (3 * BAUD) @(negedge sys_clk);
        chk("break_flags", n_flags - f0, 0);
        chk("break_ferr", n_ferr - e0, 1);
        chk("break_data", {24'd0, bus.po_data}, 32'h3C);
        idle(100);
        send_frame(8'h7E, 1'b1, BAUD, 1'b1);
        idle(100);

        // Reset during data bit 4 of 0xC5; frame is abandoned.
        f0 = n_flags;
        c5 = 8'hC5;
        bus.rx = 1'b0;
        repeat (BAUD) @(negedge sys_clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = c5[i];
            repeat (BAUD) @(negedge sys_clk);
        end
        bus.rx = c5[4];
        repeat (HALF) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        bus.rx    = 1'b1;
        @(negedge sys_clk);
        chk("midrst_po_data", {24'd0, bus.po_data}, 32'd0);
        chk("midrst_po_flag", {31'd0, bus.po_flag}, 32'd0);
        chk("midrst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        last_good = 8'h00;
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(100);
        chk("midrst_flags", n_flags - f0, 0);
        send_frame(8'h12, 1'b1, BAUD, 1'b1);
        idle(100);

        // Sender baud mismatch +2% / -2%, back-to-back random bytes.
        f0 = n_flags;
        e0 = n_ferr;
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1, BAUD + 1, 1'b0);
        end
        idle(100);
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1, BAUD - 1, 1'b0);
        end
        idle(100);
        chk("tol_flags", n_flags - f0, 32);
        chk("tol_ferr", n_ferr - e0, 0);

        waited = 0;
        while (((sb.size() != 0) || (ferr_q.size() != 0)) && (waited < 2000)) begin
            @(negedge sys_clk);
            waited++;
        end
        chk("sb_drained", sb.size(), 0);
        chk("ferr_drained", ferr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
